// File: rtl/uart_rx_sampler.sv
// UART receive front end: 2-flop synchroniser, 3-sample majority vote, LSB-first framing.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop (PARITY_ODD selects sense).
module uart_rx_sampler #(
   parameter int CLOCKS_PER_BIT = 434,
   parameter int DATA_BITS      = 8,
   parameter int COUNTER_WIDTH  = 12,
   parameter int PARITY_ODD     = 0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     rx,
   output logic [DATA_BITS-1:0]     data,
   output logic                     valid,
   output logic                     frame_error,
   output logic                     parity_error,
   output logic [COUNTER_WIDTH-1:0] frame_count,
   output logic [COUNTER_WIDTH-1:0] error_count
);

   localparam int TW = $clog2(CLOCKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] T_MID = TW'(CLOCKS_PER_BIT / 2);
   localparam logic [TW-1:0] T_END = TW'(CLOCKS_PER_BIT - 1);
   localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t               state;
   logic [1:0]           sync;
   logic [2:0]           hist;
   logic [TW-1:0]        timer;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_acc;
   logic                 par_bad;
   logic                 rx_s;
   logic                 vote;
   logic                 mid;
   logic                 wrap;

   assign rx_s = sync[1];
   assign vote = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
   assign mid  = (timer == T_MID);
   assign wrap = (timer == T_END);

   // par_acc starts at the odd/even sense so a correct frame leaves it at 0
`ifdef UART_RX_PARITY_EN
   localparam state_t AFTER_DATA = PARITY;
   assign par_bad = par_acc;
`else
   localparam state_t AFTER_DATA = STOP;
   logic unused_par;
   assign par_bad    = 1'b0;
   assign unused_par = par_acc;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         sync         <= 2'b11;
         hist         <= 3'b111;
         timer        <= '0;
         bit_idx      <= '0;
         shreg        <= '0;
         par_acc      <= 1'b0;
         data         <= '0;
         valid        <= 1'b0;
         frame_error  <= 1'b0;
         parity_error <= 1'b0;
         frame_count  <= '0;
         error_count  <= '0;
      end else begin
         sync         <= {sync[0], rx};
         hist         <= {hist[1:0], rx_s};
         valid        <= 1'b0;
         frame_error  <= 1'b0;
         parity_error <= 1'b0;
         timer        <= wrap ? '0 : timer + 1'b1;
         unique case (state)
            IDLE: begin
               if (hist[0] && !rx_s) begin
                  state   <= START;
                  timer   <= '0;
                  par_acc <= (PARITY_ODD != 0);
               end
            end
            START: begin
               if (mid && vote) begin
                  state <= IDLE;
               end else if (wrap) begin
                  state   <= DATA;
                  bit_idx <= '0;
               end
            end
            DATA: begin
               if (mid) begin
                  shreg   <= {vote, shreg[DATA_BITS-1:1]};
                  par_acc <= par_acc ^ vote;
               end
               if (wrap) begin
                  if (bit_idx == B_END) state <= AFTER_DATA;
                  else bit_idx <= bit_idx + 1'b1;
               end
            end
            PARITY: begin
               if (mid) par_acc <= par_acc ^ vote;
               if (wrap) state <= STOP;
            end
            STOP: begin
               if (mid) begin
                  if (!vote) begin
                     frame_error <= 1'b1;
                     if (error_count != '1) error_count <= error_count + 1'b1;
                     state <= WAIT_IDLE;
                  end else if (par_bad) begin
                     parity_error <= 1'b1;
                     if (error_count != '1) error_count <= error_count + 1'b1;
                     state <= IDLE;
                  end else begin
                     data  <= shreg;
                     valid <= 1'b1;
                     if (frame_count != '1) frame_count <= frame_count + 1'b1;
                     state <= IDLE;
                  end
               end
            end
            WAIT_IDLE: begin
               if (rx_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: random frames vs a frame-level model.
module tb_uart_rx_sampler;

   localparam int CPB  = 16;
   localparam int DB   = 8;
   localparam int CW   = 12;
   localparam int CWS  = 4;
   localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          rx    = 1'b1;
   logic [DB-1:0] data, data_s;
   logic          valid, frame_error, parity_error;
   logic          valid_s, frame_error_s, parity_error_s;
   logic [CW-1:0] frame_count, error_count;
   logic [CWS-1:0] frame_count_s, error_count_s;

   uart_rx_sampler #(
      .CLOCKS_PER_BIT(CPB), .DATA_BITS(DB),
      .COUNTER_WIDTH(CW), .PARITY_ODD(PODD)
   ) dut (
      .clock(clock), .reset(reset), .rx(rx),
      .data(data), .valid(valid),
      .frame_error(frame_error), .parity_error(parity_error),
      .frame_count(frame_count), .error_count(error_count)
   );

   uart_rx_sampler #(
      .CLOCKS_PER_BIT(CPB), .DATA_BITS(DB),
      .COUNTER_WIDTH(CWS), .PARITY_ODD(PODD)
   ) dut_s (
      .clock(clock), .reset(reset), .rx(rx),
      .data(data_s), .valid(valid_s),
      .frame_error(frame_error_s), .parity_error(parity_error_s),
      .frame_count(frame_count_s), .error_count(error_count_s)
   );

   always #5 clock = ~clock;

   longint cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int            kind;
      logic [DB-1:0] d;
      longint        t;
   } exp_t;

   exp_t   q[$];
   int     checks   = 0;
   int     failures = 0;
   longint mgood    = 0;
   longint merr     = 0;
   logic [DB-1:0] mlast = '0;

   function automatic longint sat(input longint v, input int w);
      longint m;
      m = (longint'(1) << w) - 1;
      return (v > m) ? m : v;
   endfunction

   task automatic chk(input string n, input longint a, input longint e);
      checks++;
      if (a != e) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at cycle %0d", n, a, e, cyc);
      end
   endtask

   // frame-level model: each strobe consumes one expected frame outcome
   always @(negedge clock) begin
      exp_t e;
      int   ka, ks;
      if (reset) begin
         mgood = 0;
         merr  = 0;
         mlast = '0;
      end else if (valid | frame_error | parity_error) begin
         chk("one_strobe", int'(valid) + int'(frame_error) + int'(parity_error), 1);
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe actual=strobe required=none at cycle %0d", cyc);
         end else begin
            e  = q.pop_front();
            ka = valid ? 0 : (frame_error ? 1 : 2);
            ks = valid_s ? 0 : (frame_error_s ? 1 : (parity_error_s ? 2 : 3));
            chk("kind", ka, e.kind);
            chk("kind_small", ks, e.kind);
            checks++;
            if (cyc < e.t - 1 || cyc > e.t + 1) begin
               failures++;
               $display("FAIL latency actual=%0d required=%0d+-1", cyc, e.t);
            end
            if (e.kind == 0) begin
               mgood++;
               mlast = e.d;
            end else begin
               merr++;
            end
            chk("data", data, mlast);
            chk("data_small", data_s, mlast);
            chk("frame_count", frame_count, sat(mgood, CW));
            chk("error_count", error_count, sat(merr, CW));
            chk("frame_count_small", frame_count_s, sat(mgood, CWS));
            chk("error_count_small", error_count_s, sat(merr, CWS));
         end
      end else if (q.size() > 0 && cyc > q[0].t + 1) begin
         checks++;
         failures++;
         $display("FAIL missing_strobe actual=none required=kind%0d by cycle %0d",
                  q[0].kind, q[0].t + 1);
         void'(q.pop_front());
      end
   end

   task automatic send(input logic [DB-1:0] d, input bit stop_ok,
                       input bit par_bad, input int hold_low);
      exp_t e;
      bit   pbit;
      @(negedge clock);
      rx     = 1'b0;
      e.kind = !stop_ok ? 1 : (par_bad ? 2 : 0);
      e.d    = d;
      e.t    = cyc + (DB + 1 + PB) * CPB + CPB / 2 + 3;
      q.push_back(e);
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < DB; i++) begin
         rx = d[i];
         repeat (CPB) @(negedge clock);
      end
      if (PB == 1) begin
         pbit = (^d) ^ (PODD != 0) ^ par_bad;
         rx   = pbit;
         repeat (CPB) @(negedge clock);
      end
      if (stop_ok) begin
         rx = 1'b1;
         repeat (CPB) @(negedge clock);
      end else begin
         rx = 1'b0;
         repeat (hold_low) @(negedge clock);
         rx = 1'b1;
         repeat (4) @(negedge clock);
      end
   endtask

   initial begin
      bit pb;
      repeat (5) @(negedge clock);
      reset = 1'b0;
      repeat (200) @(negedge clock);
      chk("rst_data", data, 0);
      chk("rst_valid", valid, 0);
      chk("rst_frame_error", frame_error, 0);
      chk("rst_parity_error", parity_error, 0);
      chk("rst_frame_count", frame_count, 0);
      chk("rst_error_count", error_count, 0);

      send(8'hA5, 1'b1, 1'b0, 0);
      repeat (10) @(negedge clock);

      rx = 1'b0;
      repeat (3) @(negedge clock);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clock);
      chk("glitch_frame_count", frame_count, 1);
      chk("glitch_error_count", error_count, 0);
      send(8'h3C, 1'b1, 1'b0, 0);

      send(8'h3C, 1'b0, 1'b0, 40);
      repeat (10) @(negedge clock);
      send(8'h55, 1'b1, 1'b0, 0);

      for (int n = 0; n < 30; n++) begin
         pb = (PB == 1) && ($urandom_range(0, 4) == 0);
         send(DB'($urandom), $urandom_range(0, 7) != 0, pb,
              $urandom_range(16, 48));
         repeat ($urandom_range(0, 12)) @(negedge clock);
      end

      for (int n = 0; n < 17; n++) send(DB'($urandom), 1'b1, 1'b0, 0);

      if (PB == 1) begin
         send(8'h07, 1'b1, 1'b1, 0);
         send(8'h07, 1'b1, 1'b0, 0);
      end

      repeat (3 * CPB) @(negedge clock);
      rx = 1'b0;
      repeat (CPB) @(negedge clock);
      rx = 1'b1;
      repeat (CPB) @(negedge clock);
      rx = 1'b0;
      repeat (CPB) @(negedge clock);
      reset = 1'b1;
      rx    = 1'b1;
      repeat (4) @(negedge clock);
      reset = 1'b0;
      repeat (20 * CPB) @(negedge clock);
      chk("midrst_data", data, 0);
      chk("midrst_frame_count", frame_count, 0);
      chk("midrst_error_count", error_count, 0);

      send(8'hC3, 1'b1, 1'b0, 0);
      repeat (2 * CPB) @(negedge clock);
      chk("queue_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
